msk_demodulator: RTL and testbench
==================================

// Module: msk_demodulator
// PURPOSE
//  Receive-side counterpart of the MSK modulator: consumes 4-bit signed I/Q half-sine
//  samples and recovers the serial bit stream by integrate-and-dump per channel.
//  Sits between the RX ADC/sample interface and the bit sink (despreader/FIFO).
//  Bits are delivered one at a time on a valid/ready handshake.
// PARAMETERS
//  SPB      8   samples per bit period T; I and Q symbol windows are 2*SPB samples
//  SW       4   sample width, two's complement
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  reset      in   1   asynchronous, active-low reset
//  i_start    in   1   1-cycle pulse: align window, clear accumulators, sample 0 follows
//  i_valid    in   1   i_sinI/i_sinQ hold a new sample this cycle
//  i_sinI     in   SW  in-phase sample, signed
//  i_sinQ     in   SW  quadrature sample, signed
//  o_valid    out  1   o_data holds a decided bit
//  o_data     out  1   recovered bit (1 = positive integral)
//  i_ready    in   1   sink accepts o_data when o_valid & i_ready
//  o_busy     out  1   aligned and integrating (set by i_start)
//  o_overrun  out  1   sticky: a bit was decided while previous bit still unaccepted
// BEHAVIOUR
//  - Reset: o_valid=0, o_data=0, o_busy=0, o_overrun=0, counters/accumulators=0.
//  - Idle until i_start; i_valid samples ignored while o_busy=0.
//  - Sample index n counts accepted samples (i_valid=1 & o_busy=1) from 0 after i_start.
//  - I window m: n in [2m*SPB, 2(m+1)*SPB); Q window m: n in [(2m+1)*SPB, (2m+3)*SPB).
//    Q window 0 opens at n=SPB; samples n<SPB do not contribute to Q.
//  - Accumulator width SW+$clog2(2*SPB)+1, signed, saturation unnecessary (sized exactly).
//  - Dump: on the sample closing a window, decision = (acc + current sample) >= 0;
//    accumulator reloads with 0 (next window starts with next sample).
//  - Bit order alternates I0,Q0,I1,Q1,...; one decision every SPB samples from n=2*SPB-1.
//  - Latency: decision registered -> o_valid=1 the cycle after the closing sample.
//  - Handshake: o_valid/o_data hold until o_valid & i_ready; then o_valid drops next
//    cycle unless a new decision lands the same cycle (new bit replaces, o_valid stays 1).
//  - Overrun: new decision while o_valid=1 & i_ready=0 -> old bit dropped, new bit
//    presented, o_overrun=1 until reset or i_start.
//  - i_valid gaps: counters and accumulators freeze; no timeout.
//  - i_start while busy: accumulators and n cleared, pending o_valid cleared, o_overrun
//    cleared; sample on same cycle as i_start is ignored.
//  - Asynchronous reset mid-window discards all partial state immediately.
//  - Zero integral decides 1 (>= 0 rule).
// STRUCTURE
//  - msk_pkg: SW, SPB defaults, ACC_W function, sample_t/acc_t typedefs.
//  - Sub-module msk_integrator (acc-and-dump: en, clr, dump, sample -> decision,
//    dump_valid), instantiated twice (I, Q).
//  - Top: window counter (mod SPB) + channel-select toggle, output register, overrun flag.
// TESTING (SPB=8)
//  - Reset: hold reset=0 with i_valid toggling -> all outputs 0, no o_valid after release.
//  - Pattern: i_start, 64 samples of modulator output for bits 1,0,1,1 -> o_data 1,0,1,1
//    with o_valid 1 cycle after samples n=15,23,31,39; i_ready=1 throughout.
//  - Constant I=+7,Q=-8: after i_start -> I decisions 1, Q decisions 0, alternating 1,0,...
//  - Backpressure: i_ready=0 across two decisions -> o_overrun=1, o_data = second bit;
//    i_start then clears o_overrun and o_valid.
//  - Gaps: insert 5-cycle i_valid=0 holes every 3 samples -> identical bit sequence to
//    gapless run.
//  - Zero input: all samples 0 -> every decision 1; mid-window reset -> no spurious o_valid.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared widths, state encoding and accumulator sizing for the MSK receive path.
package msk_pkg;

  localparam int unsigned SPB_DEF = 8;
  localparam int unsigned SW_DEF  = 4;

  // A window holds 2*spb samples; one sign bit plus headroom for that many sums.
  function automatic int unsigned acc_w(input int unsigned sw, input int unsigned spb);
    return sw + $clog2(2 * spb) + 1;
  endfunction

  localparam int unsigned ACC_W_DEF = acc_w(SW_DEF, SPB_DEF);

  typedef logic signed [SW_DEF-1:0]    sample_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  // IDLE: waiting for start; PRIME: first SPB samples, only I integrating;
  // RUN: both channels integrating, windows closing alternately.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/msk_integrator.sv
// Integrate-and-dump for one channel. The decision is combinational on the
// closing sample so the top can register it with a single cycle of latency.
module msk_integrator
  import msk_pkg::*;
#(
  parameter int unsigned SW    = SW_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 dump,
  input  logic signed [SW-1:0] sample,
  output logic                 decision,
  output logic                 dump_valid
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  // Running integral including the current sample.
  always_comb begin
    sample_ext = {{(ACC_W - SW){sample[SW-1]}}, sample};
    sum        = acc + sample_ext;
    decision   = ~sum[ACC_W-1];
    dump_valid = en & dump & ~clr;
  end

  // Accumulate accepted samples; a dump reloads zero so the next window starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= dump ? '0 : sum;
    end
  end

endmodule

// File: rtl/msk_demodulator.sv
// MSK demodulator: aligns I/Q symbol windows on i_start, integrates each
// channel over 2*SPB samples (Q offset by SPB) and presents one decided bit
// per SPB samples on a valid/ready output with a sticky overrun flag.
module msk_demodulator
  import msk_pkg::*;
#(
  parameter int unsigned SPB = SPB_DEF,
  parameter int unsigned SW  = SW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic signed [SW-1:0] i_sinI,
  input  logic signed [SW-1:0] i_sinQ,
  output logic                 o_valid,
  output logic                 o_data,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam int unsigned ACC_W = acc_w(SW, SPB);
  localparam int unsigned PH_W  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPB - 1);

  state_t          state;
  logic [PH_W-1:0] phase;
  logic            sel_q;     // 0: next closing window is I, 1: Q
  logic            accept;
  logic            wrap;
  logic            in_run;
  logic            en_i, en_q, dump_i, dump_q;
  logic            dec_i, dec_q, dv_i, dv_q;
  logic            new_bit, new_data;

  // Sample qualification and window-close decode.
  always_comb begin
    o_busy   = (state != ST_IDLE);
    accept   = i_valid & o_busy & ~i_start;
    wrap     = accept & (phase == PH_LAST);
    in_run   = (state == ST_RUN);
    en_i     = accept;
    en_q     = accept & in_run;
    dump_i   = wrap & in_run & ~sel_q;
    dump_q   = wrap & in_run & sel_q;
    new_bit  = dv_i | dv_q;
    new_data = dv_i ? dec_i : dec_q;
  end

  // Window sequencing: the first SPB samples only prime I; after that every
  // phase wrap closes a window, alternating I and Q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      phase <= '0;
      sel_q <= 1'b0;
    end else if (i_start) begin
      state <= ST_PRIME;
      phase <= '0;
      sel_q <= 1'b0;
    end else if (accept) begin
      phase <= wrap ? '0 : phase + PH_W'(1);
      if (wrap) begin
        if (state == ST_PRIME) begin
          state <= ST_RUN;
        end else begin
          sel_q <= ~sel_q;
        end
      end
    end
  end

  // Output register with handshake; a new decision always replaces the held bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid   <= 1'b0;
      o_data    <= 1'b0;
      o_overrun <= 1'b0;
    end else if (i_start) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (new_bit) begin
      o_valid <= 1'b1;
      o_data  <= new_data;
      if (o_valid && !i_ready) begin
        o_overrun <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  msk_integrator #(
    .SW    (SW),
    .ACC_W (ACC_W)
  ) u_int_i (
    .clk        (clk),
    .reset      (reset),
    .en         (en_i),
    .clr        (i_start),
    .dump       (dump_i),
    .sample     (i_sinI),
    .decision   (dec_i),
    .dump_valid (dv_i)
  );

  msk_integrator #(
    .SW    (SW),
    .ACC_W (ACC_W)
  ) u_int_q (
    .clk        (clk),
    .reset      (reset),
    .en         (en_q),
    .clr        (i_start),
    .dump       (dump_q),
    .sample     (i_sinQ),
    .decision   (dec_q),
    .dump_valid (dv_q)
  );

endmodule

// File: tb/tb_msk_demodulator.sv
// Directed bench for msk_demodulator with SPB=8, SW=4.
module tb_msk_demodulator;

  localparam int SPB = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_start = 1'b0;
  logic              i_valid = 1'b0;
  logic signed [3:0] i_sinI = '0;
  logic signed [3:0] i_sinQ = '0;
  logic              o_valid, o_data, o_busy, o_overrun;
  logic              i_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int valid_seen = 0;
  int q_bit[$];
  int q_n[$];

  // Half-sine, amplitude 7, 16 samples per I/Q symbol.
  int hs[16] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 6, 5, 4, 3, 2, 1};
  // Bit stream I0,Q0,I1,Q1,... = 1,0,1,1,0,1,0,0 (LSB first).
  logic [7:0] bits = 8'b0010_1101;

  msk_demodulator #(.SPB(8), .SW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .i_sinI    (i_sinI),
    .i_sinQ    (i_sinQ),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  // Record accepted bits and the index of the last sample sent at that point.
  always @(negedge clk) begin
    if (o_valid) valid_seen++;
    if (o_valid && i_ready && reset) begin
      q_bit.push_back(int'(o_data));
      q_n.push_back(n_sent - 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    i_start = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    n_sent = 0;
    q_bit.delete();
    q_n.delete();
  endtask

  task automatic send(input logic signed [3:0] si, input logic signed [3:0] sq);
    @(negedge clk);
    i_valid = 1'b1;
    i_sinI  = si;
    i_sinQ  = sq;
    @(posedge clk);
    #1;
    n_sent++;
    i_valid = 1'b0;
  endtask

  // kind 0: modulated pattern, 1: constant I=+7 Q=-8, 2: all zero
  task automatic gen(input int kind, input int n, output logic signed [3:0] si,
                     output logic signed [3:0] sq);
    int vi, vq, m;
    vi = 0;
    vq = 0;
    if (kind == 0) begin
      m  = n / 16;
      vi = bits[2*m] ? hs[n % 16] : -hs[n % 16];
      if (n >= SPB) begin
        m  = (n - SPB) / 16;
        vq = bits[2*m+1] ? hs[(n - SPB) % 16] : -hs[(n - SPB) % 16];
      end
    end else if (kind == 1) begin
      vi = 7;
      vq = -8;
    end
    si = 4'(vi);
    sq = 4'(vq);
  endtask

  task automatic run(input int kind, input int nsamp, input bit gaps);
    logic signed [3:0] si, sq;
    do_start();
    for (int n = 0; n < nsamp; n++) begin
      gen(kind, n, si, sq);
      send(si, sq);
      if (gaps && (n % 3 == 2)) repeat (5) @(posedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_seq(input string tag, input int kind, input int ndec);
    int eb;
    check({tag, "_count"}, q_bit.size(), ndec);
    for (int k = 0; k < ndec && k < q_bit.size(); k++) begin
      if (kind == 0)      eb = int'(bits[k]);
      else if (kind == 1) eb = (k % 2 == 0) ? 1 : 0;
      else                eb = 1;
      check($sformatf("%s_bit%0d", tag, k), q_bit[k], eb);
      check($sformatf("%s_n%0d", tag, k), q_n[k], 2*SPB - 1 + SPB*k);
    end
  endtask

  initial begin
    // Reset held with i_valid toggling.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i_valid = ~i_valid;
    end
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovr", o_overrun, 0);
    reset = 1'b1;
    valid_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_valid = ~i_valid;
    end
    i_valid = 1'b0;
    check("idle_no_valid", valid_seen, 0);
    check("idle_busy", o_busy, 0);

    // Modulated pattern, gapless then with holes.
    run(0, 64, 1'b0);
    check("pat_busy", o_busy, 1);
    check_seq("pat", 0, 7);
    run(0, 64, 1'b1);
    check_seq("gap", 0, 7);

    // Constant input.
    run(1, 48, 1'b0);
    check_seq("const", 1, 5);

    // Backpressure / overrun.
    i_ready = 1'b0;
    do_start();
    for (int n = 0; n < 16; n++) send(4'sd7, -4'sd8);
    @(negedge clk);
    check("bp_valid1", o_valid, 1);
    check("bp_data1", o_data, 1);
    check("bp_ovr1", o_overrun, 0);
    for (int n = 16; n < 24; n++) send(4'sd7, -4'sd8);
    @(negedge clk);
    check("bp_valid2", o_valid, 1);
    check("bp_data2", o_data, 0);
    check("bp_ovr2", o_overrun, 1);
    do_start();
    @(negedge clk);
    check("bp_start_valid", o_valid, 0);
    check("bp_start_ovr", o_overrun, 0);
    i_ready = 1'b1;

    // Zero input decides 1.
    run(2, 40, 1'b0);
    check_seq("zero", 2, 4);

    // Mid-window reset discards partial state.
    do_start();
    for (int n = 0; n < 10; n++) send(4'sd0, 4'sd0);
    valid_seen = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) send(4'sd0, 4'sd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_valid", valid_seen, 0);
    run(1, 16, 1'b0);
    check_seq("post_rst", 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
